// File: rtl/topk_collector_if.sv
// Ready/valid result stream from topk_collector toward the host side.
interface topk_collector_if;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;

   modport master (output out_data, output out_valid, input out_ready);
   modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/topk_collector.sv
// Captures up to k search results per query, then replays them in arrival order on a ready/valid stream.
// Optional TOPK_COLLECTOR_DEDUP_EN drops results already held in the buffer during capture.
module topk_collector #(
   parameter int unsigned K_MAX          = 8,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     start_in,
   input  logic [15:0]              k_in,
   input  logic [31:0]              result_in,
   input  logic                     result_valid_in,
   topk_collector_if.master         out_if,
   output logic [$clog2(K_MAX):0]   count_out,
   output logic                     done_out,
   output logic                     overflow_out,
   output logic                     timeout_out
);
   localparam int unsigned PW = $clog2(K_MAX);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN, S_DONE} state_t;

   state_t         state_q, state_d;
   logic [31:0]    buf_q [K_MAX];
   logic [CW-1:0]  count_q;
   logic [CW-1:0]  k_eff_q;
   logic [PW-1:0]  rd_ptr_q;
   logic [TW-1:0]  tmo_q;
   logic           overflow_q;
   logic           timeout_q;

   logic [CW-1:0]  k_start_c;
   logic           dup_hit_c;
   logic           accept_c;
   logic           last_accept_c;
   logic           tmo_hit_c;
   logic           xfer_c;
   logic           last_xfer_c;

   // k_eff clamp evaluated at full 16-bit width before narrowing
   assign k_start_c = (k_in > 16'(K_MAX)) ? CW'(K_MAX) : CW'(k_in);

`ifdef TOPK_COLLECTOR_DEDUP_EN
   always_comb begin
      dup_hit_c = 1'b0;
      for (int i = 0; i < int'(K_MAX); i++) begin
         if ((CW'(i) < count_q) && (buf_q[i] == result_in)) dup_hit_c = 1'b1;
      end
   end
`else
   assign dup_hit_c = 1'b0;
`endif

   assign accept_c      = (state_q == S_COLLECT) && !start_in && result_valid_in && !dup_hit_c;
   assign last_accept_c = accept_c && ((count_q + CW'(1)) == k_eff_q);
   assign tmo_hit_c     = (state_q == S_COLLECT) && !accept_c && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
   assign xfer_c        = (state_q == S_DRAIN) && out_if.out_ready;
   assign last_xfer_c   = xfer_c && (CW'(rd_ptr_q) == (count_q - CW'(1)));

   // State register
   always_ff @(posedge clk_in) begin
      if (rst_in) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; start_in overrides every state
   always_comb begin
      state_d = state_q;
      if (start_in) begin
         state_d = (k_start_c == '0) ? S_DONE : S_COLLECT;
      end else begin
         case (state_q)
            S_COLLECT: begin
               if (last_accept_c)  state_d = S_DRAIN;
               else if (tmo_hit_c) state_d = (count_q == '0) ? S_DONE : S_DRAIN;
            end
            S_DRAIN: begin
               if (last_xfer_c) state_d = S_DONE;
            end
            default: state_d = state_q;
         endcase
      end
   end

   // Outputs decoded from registered state and buffer
   always_comb begin
      out_if.out_valid = 1'b0;
      done_out         = 1'b0;
      out_if.out_data  = buf_q[rd_ptr_q];
      case (state_q)
         S_DRAIN: out_if.out_valid = 1'b1;
         S_DONE:  done_out         = 1'b1;
         default: ;
      endcase
   end

   assign count_out    = count_q;
   assign overflow_out = overflow_q;
   assign timeout_out  = timeout_q;

   // Capture buffer, pointers, timeout counter and sticky flags
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int i = 0; i < int'(K_MAX); i++) buf_q[i] <= '0;
         count_q    <= '0;
         k_eff_q    <= '0;
         rd_ptr_q   <= '0;
         tmo_q      <= '0;
         overflow_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else if (start_in) begin
         k_eff_q    <= k_start_c;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         tmo_q      <= '0;
         overflow_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         if (accept_c) begin
            buf_q[count_q[PW-1:0]] <= result_in;
            count_q                <= count_q + CW'(1);
            tmo_q                  <= '0;
         end else if (state_q == S_COLLECT) begin
            if (tmo_hit_c)    timeout_q <= 1'b1;
            if (tmo_q != '1)  tmo_q     <= tmo_q + TW'(1);
         end
         if (result_valid_in && ((state_q == S_DRAIN) || (state_q == S_DONE))) overflow_q <= 1'b1;
         if (xfer_c) rd_ptr_q <= rd_ptr_q + PW'(1);
      end
   end
endmodule

// File: tb/tb_topk_collector.sv
// Scoreboard bench for topk_collector: directed queries, monitor pops expected results on each transfer.
module tb_topk_collector;
   localparam int unsigned K_MAX = 8;
   localparam int unsigned TMO   = 1024;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic        start_in = 1'b0;
   logic [15:0] k_in = '0;
   logic [31:0] result_in = '0;
   logic        result_valid_in = 1'b0;
   logic [3:0]  count_out;
   logic        done_out, overflow_out, timeout_out;

   topk_collector_if out_if ();

   topk_collector #(.K_MAX(K_MAX), .TIMEOUT_CYCLES(TMO)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .k_in(k_in),
      .result_in(result_in), .result_valid_in(result_valid_in), .out_if(out_if),
      .count_out(count_out), .done_out(done_out), .overflow_out(overflow_out),
      .timeout_out(timeout_out));

   always #5 clk_in = ~clk_in;

   int          total = 0;
   int          bad = 0;
   int          valid_cycles = 0;
   logic [31:0] exp_q [$];
   logic        held = 1'b0;
   logic [31:0] held_data = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Monitor: compares every transfer with the scoreboard and checks stall stability
   always @(negedge clk_in) begin
      if (!rst_in) begin
         if (out_if.out_valid) begin
            valid_cycles++;
            if (held) chk("stall_stable", out_if.out_data, held_data);
            if (out_if.out_ready) begin
               held = 1'b0;
               if (exp_q.size() == 0) chk("unexpected_xfer", out_if.out_data, 32'hdead_beef);
               else chk("xfer_data", out_if.out_data, exp_q.pop_front());
            end else begin
               held = 1'b1;
               held_data = out_if.out_data;
            end
         end else begin
            held = 1'b0;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic do_start(input logic [15:0] k);
      start_in = 1'b1; k_in = k;
      tick(1);
      start_in = 1'b0;
   endtask

   task automatic strobe(input logic [31:0] v, input bit expect_out);
      result_in = v; result_valid_in = 1'b1;
      if (expect_out) exp_q.push_back(v);
      tick(1);
      result_valid_in = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (!done_out && n < budget) begin tick(1); n++; end
      chk("done_reached", 32'(done_out), 32'd1);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
   endtask

   logic [15:0] pat;
   int          vc0;

   initial begin
      out_if.out_ready = 1'b1;
      // Reset state
      tick(2);
      chk("rst_valid", 32'(out_if.out_valid), 0);
      chk("rst_done", 32'(done_out), 0);
      chk("rst_ovf", 32'(overflow_out), 0);
      chk("rst_tmo", 32'(timeout_out), 0);
      chk("rst_count", 32'(count_out), 0);
      chk("rst_data", out_if.out_data, 0);
      rst_in = 1'b0;
      tick(1);

      // Basic capture, one transfer per cycle
      do_start(16'd4);
      strobe(32'h10, 1); tick(2);
      strobe(32'h20, 1); tick(1);
      strobe(32'h30, 1); tick(3);
      strobe(32'h40, 1);
      chk("basic_count", 32'(count_out), 4);
      chk("basic_first_valid", 32'(out_if.out_valid), 1);
      chk("basic_first_data", out_if.out_data, 32'h10);
      tick(3);
      chk("basic_not_done_yet", 32'(done_out), 0);
      tick(1);
      chk("basic_done", 32'(done_out), 1);
      chk("basic_ovf", 32'(overflow_out), 0);
      wait_done(4);

      // k above capacity, late strobes overflow
      do_start(16'd20);
      for (int i = 1; i <= 10; i++) strobe(32'(i), i <= 8);
      wait_done(20);
      chk("cap_count", 32'(count_out), 8);
      chk("cap_ovf", 32'(overflow_out), 1);
      chk("cap_tmo", 32'(timeout_out), 0);

      // Timeout with partial capture, exact boundary
      do_start(16'd4);
      strobe(32'hA1, 1);
      strobe(32'hA2, 1);
      tick(TMO - 1);
      chk("tmo_pre_flag", 32'(timeout_out), 0);
      chk("tmo_pre_valid", 32'(out_if.out_valid), 0);
      tick(1);
      chk("tmo_flag", 32'(timeout_out), 1);
      chk("tmo_valid", 32'(out_if.out_valid), 1);
      wait_done(8);
      chk("tmo_count", 32'(count_out), 2);

      // Timeout with nothing captured goes straight to DONE
      vc0 = valid_cycles;
      do_start(16'd4);
      tick(TMO - 1);
      chk("tmo0_pre_done", 32'(done_out), 0);
      tick(1);
      chk("tmo0_done", 32'(done_out), 1);
      chk("tmo0_flag", 32'(timeout_out), 1);
      chk("tmo0_count", 32'(count_out), 0);
      chk("tmo0_no_valid", 32'(valid_cycles - vc0), 0);

      // k = 0 is immediately done, no timeout flag
      do_start(16'd0);
      chk("k0_done", 32'(done_out), 1);
      chk("k0_tmo", 32'(timeout_out), 0);

      // Backpressure during drain
      out_if.out_ready = 1'b0;
      do_start(16'd5);
      for (int i = 0; i < 5; i++) strobe(32'h51 + 32'(i), 1);
      pat = 16'b1001_0110_0010_1100;
      for (int i = 0; i < 64 && !done_out; i++) begin
         out_if.out_ready = pat[i % 16];
         tick(1);
      end
      out_if.out_ready = 1'b1;
      wait_done(8);
      chk("bp_count", 32'(count_out), 5);

      // Abort in the middle of a drain
      out_if.out_ready = 1'b0;
      do_start(16'd4);
      strobe(32'h61, 1);
      strobe(32'h62, 0);
      strobe(32'h63, 0);
      strobe(32'h64, 0);
      tick(2);
      out_if.out_ready = 1'b1;
      tick(1);
      out_if.out_ready = 1'b0;
      do_start(16'd2);
      chk("abort_count", 32'(count_out), 0);
      chk("abort_valid", 32'(out_if.out_valid), 0);
      chk("abort_done", 32'(done_out), 0);
      strobe(32'h71, 1);
      strobe(32'h72, 1);
      out_if.out_ready = 1'b1;
      wait_done(8);
      chk("abort_new_count", 32'(count_out), 2);

      // Reset in the middle of a capture
      do_start(16'd4);
      strobe(32'h81, 0);
      strobe(32'h82, 0);
      rst_in = 1'b1;
      tick(1);
      chk("mrst_valid", 32'(out_if.out_valid), 0);
      chk("mrst_done", 32'(done_out), 0);
      chk("mrst_count", 32'(count_out), 0);
      chk("mrst_tmo", 32'(timeout_out), 0);
      chk("mrst_data", out_if.out_data, 0);
      rst_in = 1'b0;
      tick(1);

      // Strobe while idle is ignored silently
      strobe(32'h99, 0);
      chk("idle_count", 32'(count_out), 0);
      chk("idle_ovf", 32'(overflow_out), 0);

      // Duplicate handling
      do_start(16'd3);
`ifdef TOPK_COLLECTOR_DEDUP_EN
      strobe(32'h5, 1); strobe(32'h5, 0); strobe(32'h7, 1); strobe(32'h5, 0); strobe(32'h9, 1);
      wait_done(8);
      chk("dedup_ovf", 32'(overflow_out), 0);
`else
      strobe(32'h5, 1); strobe(32'h5, 1); strobe(32'h7, 1); strobe(32'h5, 0); strobe(32'h9, 0);
      wait_done(8);
      chk("dup_ovf", 32'(overflow_out), 1);
`endif
      chk("dup_count", 32'(count_out), 3);

      tick(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got expired want finished");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/topk_collector.md
# topk_collector

Downstream consumer of the best-first search core's result stream. Captures the `top_k_out` / `valid_out` pulses for one query into a small register buffer and bounds the capture to the requested k. After k results arrive, or after a silence timeout, it replays them in arrival order on a ready/valid stream toward the host/UART side. It also flags overflow and timeout conditions per query.

## Interface
Parameters:
- `K_MAX`, default 8: buffer depth; maximum results kept per query (power of two, ≥2).
- `TIMEOUT_CYCLES`, default 1024: idle cycles in COLLECT, with no accepted result, before the capture is closed early.

Ports:
- `clk_in`  in  1  single clock; all logic on posedge.
- `rst_in`  in  1  reset, synchronous, active-high.
- `start_in`  in  1  one-cycle pulse that begins a new query capture.
- `k_in`  in  16  requested result count; sampled only on `start_in`.
- `result_in`  in  32  result word from the search core (`top_k_out`).
- `result_valid_in`  in  1  result strobe (`valid_out` of the search core); no backpressure.
- `out_data`  out  32  buffered result being offered.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  sink accepts `out_data` this cycle.
- `count_out`  out  $clog2(K_MAX)+1  results captured for the current query.
- `done_out`  out  1  level, high in DONE.
- `overflow_out`  out  1  sticky: a strobe arrived after the capture was full.
- `timeout_out`  out  1  sticky: the capture was closed by timeout.

## Operation
- States: IDLE, COLLECT, DRAIN, DONE. Reset enters IDLE.
- Reset values:
  - `out_valid`, `done_out`, `overflow_out`, `timeout_out` = 0.
  - `count_out` = 0.
  - `out_data` = 0.
  - Buffer pointers = 0.
- `start_in` in any state:
  - Latch `k_eff = min(k_in, K_MAX)`.
  - Clear count, pointers, timeout counter, `overflow_out`, `timeout_out`.
  - Go to COLLECT, or go directly to DONE if `k_eff == 0`.
  - A `start_in` in COLLECT or DRAIN aborts the current query; undrained results are discarded.
- COLLECT:
  - Each `result_valid_in` cycle writes `result_in` to `buf[count]`, increments count, and clears the timeout counter.
  - When count reaches `k_eff`, go to DRAIN.
  - Otherwise the timeout counter increments each cycle. When it hits `TIMEOUT_CYCLES-1`, set `timeout_out` and go to DRAIN, or go to DONE if count == 0.
- Strobes outside COLLECT:
  - A strobe in DRAIN or DONE is dropped and sets `overflow_out`.
  - A strobe in IDLE is dropped silently.
- DRAIN:
  - `out_valid` = 1 and `out_data = buf[rd_ptr]`.
  - On `out_valid && out_ready`, `rd_ptr` increments.
  - The transfer with `rd_ptr == count-1` moves to DONE.
- DONE: `done_out` = 1; results are held but not re-offered. Leaves DONE only on `start_in` or reset.
- `count_out` holds its final value through DRAIN and DONE until the next `start_in`.
- Widths:
  - The timeout counter is `$clog2(TIMEOUT_CYCLES)+1` bits and saturates.
  - The `k_eff` comparison is done at 16 bits before truncation.

## Timing
- Result accepted in cycle t is visible in `count_out` at t+1.
- The k-th result accepted at t puts DRAIN state and `out_valid` = 1 at t+1, with `out_data` = first result.
- `out_data` is a mux of registered buffer entries, with no read latency.
- `out_data` and `out_valid` stay stable while `out_valid && !out_ready`. `out_valid` never depends combinationally on `out_ready`.
- With `out_ready` held high, one result transfers per cycle. `done_out` rises the cycle after the last transfer.
- A strobe in the same cycle as `start_in` is dropped; capture begins the following cycle.
- The timeout closes exactly `TIMEOUT_CYCLES` cycles after entering COLLECT, or after the last accept.

## Configuration
- `TOPK_COLLECTOR_DEDUP_EN` defined:
  - In COLLECT, a `result_in` equal to any of the first count buffer entries is dropped.
  - A dropped duplicate does not increment count, does not clear the timeout counter, and does not set `overflow_out`.
  - The comparison is against registered entries only. A duplicate of the result accepted in the same cycle cannot occur, because there is one strobe per cycle.
- Undefined: every strobe in COLLECT is stored, duplicates included.

## Test plan
- Basic capture: start with k=4; strobe 0x10, 0x20, 0x30, 0x40 with gaps; `out_ready`=1 → outputs 0x10..0x40 in order on 4 consecutive cycles, `count_out`=4, then `done_out`=1.
- k above capacity and overflow: start with k=20 (K_MAX=8); strobe 10 results → 8 drained, `overflow_out`=1, `count_out`=8.
- Timeout, both paths: start with k=4; strobe 2 results then idle → after 1024 idle cycles `timeout_out`=1 and 2 results drained. Start again with zero strobes → DONE directly, `out_valid` never asserted.
- Backpressure: toggle `out_ready` randomly during drain → every result appears exactly once, `out_data` stable while stalled.
- Abort and reset: `start_in` mid-DRAIN → remaining results discarded, `count_out`=0, new capture works. `rst_in` mid-COLLECT → all outputs at reset values the next cycle.
- Dedup: with `TOPK_COLLECTOR_DEDUP_EN`, k=3, strobes 5, 5, 7, 5, 9 → drained 5, 7, 9. Without the macro → drained 5, 5, 7.
